sprite_lane_compositor: RTL and testbench
=========================================

SPRITE_LANE_COMPOSITOR -- requirements
Module: sprite_lane_compositor

Interface
REQ-001 SHALL have parameter LANES, default 4, number of adjacent screen pixels composited per instance.
REQ-002 SHALL have parameter TEX_W, default 16, texels per texture row.
REQ-003 SHALL have parameter TEX_ROWS, default 2, texture rows per fragment.
REQ-004 SHALL have parameter ROW, default 0, texture row sampled by this instance (0..TEX_ROWS-1).
REQ-005 SHALL have parameter BASE_X, default 0, screen x of lane 0; lane i sits at BASE_X+i.
REQ-006 SHALL have parameters COLOR_W (default 8), Z_W (default 8), X_W (default 4), KEY (default 255, transparent color), BG (default 0, clear color).
REQ-007 SHALL provide ports:
 clk  in  1  clock, all state on rising edge
 reset  in  1  asynchronous, active-high reset
 frame_start  in  1  begin new frame (pulse)
 frame_end  in  1  close frame, start drain (pulse)
 in_valid  in  1  fragment valid
 in_ready  out  1  fragment accepted when in_valid&&in_ready
 in_tex  in  TEX_ROWS*TEX_W*COLOR_W  texels; texel (r,c) at bits [(r*TEX_W+c)*COLOR_W +: COLOR_W]
 in_start_x  in  X_W  screen x of texel column 0
 in_z  in  Z_W  fragment depth, larger = nearer
 out_valid  out  1  drained color valid
 out_ready  in  1  sink accepts
 out_color  out  COLOR_W  lane color
 out_last  out  1  high with final lane
 busy  out  1  state != IDLE

Function
REQ-008 SHALL implement states IDLE, CLEAR, ACCEPT, DRAIN.
REQ-009 IDLE: frame_start -> CLEAR; all other inputs ignored.
REQ-010 CLEAR: one cycle; every lane depth <= 0, color <= BG; next state ACCEPT.
REQ-011 ACCEPT: in_ready=1; in_ready=0 in every other state.
REQ-012 On accepted fragment, all lanes SHALL update in the same cycle (1-cycle latency, throughput 1 fragment/cycle).
REQ-013 Lane i texel column c = (BASE_X+i) - in_start_x, computed at X_W+2 bits signed; lane hit only if 0 <= c < TEX_W.
REQ-014 Lane i writes color=texel(ROW,c), depth=in_z when hit && stored_depth <= in_z && (in_z==0 || texel != KEY); else unchanged.
REQ-015 ACCEPT: frame_end -> DRAIN; fragment accepted in same cycle SHALL be applied before draining.
REQ-016 ACCEPT: frame_start (priority over frame_end) -> CLEAR; same-cycle fragment discarded.
REQ-017 DRAIN: out_valid=1, out_color = lane k color, k starting 0; k increments on out_valid&&out_ready; out_color stable while stalled.
REQ-018 out_last=1 exactly when k==LANES-1; handshake on last -> IDLE, k <= 0.
REQ-019 frame_start, frame_end, in_valid SHALL be ignored during CLEAR and DRAIN.
REQ-020 Depth compare SHALL be unsigned Z_W bits; no wrap.

Reset
REQ-021 reset asserted SHALL asynchronously force state IDLE, k=0, all lane depths 0, colors BG.
REQ-022 Outputs during/after reset: in_ready=0, out_valid=0, out_last=0, busy=0, out_color=BG.
REQ-023 reset mid-DRAIN or mid-ACCEPT SHALL abandon frame; no partial output after release.

Configuration
REQ-024 Macro SPRITE_LANE_BLEND_EN: when defined, a write with in_z equal to stored depth (and stored depth != 0) SHALL store (old+new)>>1 at COLOR_W+1 bits; strictly-nearer writes replace.
REQ-025 Without SPRITE_LANE_BLEND_EN, equal-depth writes SHALL replace color (REQ-014 only).

Verification
REQ-026 reset, frame_start, frame_end, out_ready=1 -> 4 outputs all BG=0, out_last on 4th, busy falls next cycle.
REQ-027 BASE_X=0, fragment start_x=2, z=5, row texels c=k -> lanes 0,1 = 0, lanes 2,3 = 0,1.
REQ-028 Fragment z=5 color 10 then z=3 color 20 same lanes -> drained 10; reversed order -> 10.
REQ-029 Texel 255 at z=4 -> lane unchanged; texel 255 at z=0 on cleared lane -> lane = 255.
REQ-030 out_ready held 0 three cycles in DRAIN -> out_color/out_last stable; reset asserted mid-drain -> out_valid 0 immediately.
REQ-031 BLEND_EN defined: z=5 color 10 then z=5 color 21 -> 15; undefined -> 21.

Source files
------------

// File: rtl/sprite_lane_compositor.sv
// Depth-tested sprite compositor for LANES adjacent screen pixels sampling one texture row.
// Optional `SPRITE_LANE_BLEND_EN averages colors on equal-depth writes instead of replacing.
module sprite_lane_compositor #(
  parameter int LANES    = 4,
  parameter int TEX_W    = 16,
  parameter int TEX_ROWS = 2,
  parameter int ROW      = 0,
  parameter int BASE_X   = 0,
  parameter int COLOR_W  = 8,
  parameter int Z_W      = 8,
  parameter int X_W      = 4,
  parameter int KEY      = 255,
  parameter int BG       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_start,
  input  logic                              frame_end,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TEX_ROWS*TEX_W*COLOR_W-1:0] in_tex,
  input  logic [X_W-1:0]                    in_start_x,
  input  logic [Z_W-1:0]                    in_z,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLOR_W-1:0]                out_color,
  output logic                              out_last,
  output logic                              busy
);

  localparam int K_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [K_W-1:0]     K_LAST = K_W'(LANES - 1);
  localparam logic [COLOR_W-1:0] KEY_C  = COLOR_W'(KEY);
  localparam logic [COLOR_W-1:0] BG_C   = COLOR_W'(BG);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCEPT, DRAIN} state_t;

  state_t               state, state_next;
  logic [K_W-1:0]       k;
  logic [COLOR_W-1:0]   lane_color [LANES];
  logic [Z_W-1:0]       lane_depth [LANES];
  logic [COLOR_W-1:0]   wr_color   [LANES];
  logic [LANES-1:0]     wr_en;
  logic                 accept_frag;
  logic                 clear_lanes;
  logic [TEX_W*COLOR_W-1:0] row_bits;
  logic                 tex_unused;

  assign row_bits   = in_tex[ROW*TEX_W*COLOR_W +: TEX_W*COLOR_W];
  assign tex_unused = ^in_tex;

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept_frag = 1'b0;
    clear_lanes = 1'b0;
    case (state)
      IDLE: if (frame_start) state_next = CLEAR;
      CLEAR: begin
        clear_lanes = 1'b1;
        state_next  = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        // A restart wins over everything, including a fragment in the same cycle.
        if (frame_start) begin
          state_next = CLEAR;
        end else begin
          accept_frag = in_valid;
          if (frame_end) state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && k == K_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_last  = (state == DRAIN) && (k == K_LAST);
  assign out_color = (state == DRAIN) ? lane_color[k] : BG_C;

  for (genvar i = 0; i < LANES; i++) begin : lane_g
    localparam logic signed [X_W+1:0] LANE_X = (X_W+2)'(BASE_X + i);
    logic signed [X_W+1:0] col;
    logic                  hit;
    logic [X_W:0]          sel;
    logic [COLOR_W-1:0]    texel;
    logic                  nearer_ok;

    assign col       = LANE_X - $signed({2'b00, in_start_x});
    assign hit       = !col[X_W+1] && (int'(col) < TEX_W);
    assign sel       = hit ? col[X_W:0] : '0;
    assign texel     = row_bits[sel*COLOR_W +: COLOR_W];
    assign nearer_ok = (lane_depth[i] <= in_z) && ((in_z == '0) || (texel != KEY_C));
    assign wr_en[i]  = accept_frag && hit && nearer_ok;

`ifdef SPRITE_LANE_BLEND_EN
    logic [COLOR_W:0] sum;
    logic             blend;
    assign sum         = {1'b0, lane_color[i]} + {1'b0, texel};
    assign blend       = (lane_depth[i] == in_z) && (lane_depth[i] != '0);
    assign wr_color[i] = blend ? sum[COLOR_W:1] : texel;
`else
    assign wr_color[i] = texel;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        lane_depth[i] <= '0;
        lane_color[i] <= BG_C;
      end
    end else if (clear_lanes) begin
      for (int i = 0; i < LANES; i++) begin
        lane_depth[i] <= '0;
        lane_color[i] <= BG_C;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_en[i]) begin
          lane_depth[i] <= in_z;
          lane_color[i] <= wr_color[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      if (state == DRAIN && out_ready) k <= (k == K_LAST) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_lane_compositor.sv
// Directed bench for sprite_lane_compositor: frame-level model with a drain scoreboard plus literal lane checks.
module tb_sprite_lane_compositor;

  localparam int LANES = 4, TEX_W = 16, TEX_ROWS = 2, ROW = 0, BASE_X = 0;
  localparam int COLOR_W = 8, Z_W = 8, X_W = 4, KEY = 255, BG = 0;
  localparam int TEX_BITS = TEX_ROWS * TEX_W * COLOR_W;

  logic                clk, reset, frame_start, frame_end, in_valid, in_ready;
  logic [TEX_BITS-1:0] in_tex;
  logic [X_W-1:0]      in_start_x;
  logic [Z_W-1:0]      in_z;
  logic                out_valid, out_ready, out_last, busy;
  logic [COLOR_W-1:0]  out_color;

  sprite_lane_compositor #(
    .LANES(LANES), .TEX_W(TEX_W), .TEX_ROWS(TEX_ROWS), .ROW(ROW), .BASE_X(BASE_X),
    .COLOR_W(COLOR_W), .Z_W(Z_W), .X_W(X_W), .KEY(KEY), .BG(BG)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_tex(in_tex), .in_start_x(in_start_x),
    .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level model: lanes as integers, drained colors as a queue.
  typedef enum {M_IDLE, M_CLEAR, M_ACCEPT, M_DRAIN} mode_t;
  mode_t mode;
  int    m_color [LANES];
  int    m_depth [LANES];
  int    exp_q [$];

  function automatic int texel_at(input logic [TEX_BITS-1:0] tex, input int r, input int c);
    return int'(tex[(r*TEX_W + c)*COLOR_W +: COLOR_W]);
  endfunction

  task automatic model_fragment(input logic [TEX_BITS-1:0] tex, input int sx, input int z);
    for (int i = 0; i < LANES; i++) begin
      int c, t;
      c = BASE_X + i - sx;
      if (c >= 0 && c < TEX_W) begin
        t = texel_at(tex, ROW, c);
        if (m_depth[i] <= z && (z == 0 || t != KEY)) begin
`ifdef SPRITE_LANE_BLEND_EN
          if (z == m_depth[i] && m_depth[i] != 0) m_color[i] = (m_color[i] + t) / 2;
          else m_color[i] = t;
`else
          m_color[i] = t;
`endif
          m_depth[i] = z;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mode = M_IDLE;
      exp_q.delete();
      for (int i = 0; i < LANES; i++) begin m_color[i] = BG; m_depth[i] = 0; end
    end else begin
      case (mode)
        M_IDLE: if (frame_start) mode = M_CLEAR;
        M_CLEAR: begin
          for (int i = 0; i < LANES; i++) begin m_color[i] = BG; m_depth[i] = 0; end
          mode = M_ACCEPT;
        end
        M_ACCEPT: begin
          if (frame_start) mode = M_CLEAR;
          else begin
            if (in_valid) model_fragment(in_tex, int'(in_start_x), int'(in_z));
            if (frame_end) begin
              for (int i = 0; i < LANES; i++) exp_q.push_back(m_color[i]);
              mode = M_DRAIN;
            end
          end
        end
        M_DRAIN: if (out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) mode = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", int'(in_ready), int'(mode == M_ACCEPT));
    checkOutput("out_valid", int'(out_valid), int'(mode == M_DRAIN));
    checkOutput("busy", int'(busy), int'(mode != M_IDLE));
    if (mode == M_DRAIN) begin
      checkOutput("out_color", int'(out_color), exp_q[0]);
      checkOutput("out_last", int'(out_last), int'(exp_q.size() == 1));
    end else begin
      checkOutput("out_color_idle", int'(out_color), BG);
      checkOutput("out_last_idle", int'(out_last), 0);
    end
  end

  task automatic applyStimulus(input bit fs, input bit fe, input bit v,
                               input logic [TEX_BITS-1:0] tex, input int sx, input int z,
                               input bit ordy);
    frame_start = fs; frame_end = fe; in_valid = v; in_tex = tex;
    in_start_x = X_W'(sx); in_z = Z_W'(z); out_ready = ordy;
    @(posedge clk); #1;
    frame_start = 1'b0; frame_end = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic startFrame();
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    idleCycle();
  endtask

  task automatic frag(input logic [TEX_BITS-1:0] tex, input int sx, input int z);
    applyStimulus(0, 0, 1, tex, sx, z, 0);
  endtask

  task automatic endFrame();
    applyStimulus(0, 1, 0, '0, 0, 0, 0);
  endtask

  // kind 0: every texel = val; kind 1: row ROW column c = c+val, other rows 0xAA
  function automatic logic [TEX_BITS-1:0] make_tex(input int kind, input int val);
    logic [TEX_BITS-1:0] t;
    t = '0;
    for (int r = 0; r < TEX_ROWS; r++)
      for (int c = 0; c < TEX_W; c++)
        t[(r*TEX_W + c)*COLOR_W +: COLOR_W] =
          COLOR_W'((kind == 0) ? val : ((r == ROW) ? c + val : 8'hAA));
    return t;
  endfunction

  int cap [LANES];

  task automatic drainAll(input string name);
    int  got;
    bit  done;
    got = 0; done = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (out_valid) begin
        if (got < LANES) cap[got] = int'(out_color);
        got++;
        done = out_last;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput({name, "_drain_count"}, got, LANES);
  endtask

  task automatic checkLanes(input string name, input int e0, input int e1, input int e2, input int e3);
    int e [LANES];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < LANES; i++) begin
      checkOutput($sformatf("%s_lane%0d", name, i), cap[i], e[i]);
      checkOutput($sformatf("%s_model%0d", name, i), m_color[i], e[i]);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 0; frame_end = 0; in_valid = 0; in_tex = '0;
    in_start_x = '0; in_z = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_color", int'(out_color), BG);
    reset = 1'b0;
    applyStimulus(0, 1, 1, make_tex(0, 9), 0, 3, 1);

    startFrame(); endFrame(); drainAll("empty");
    checkLanes("empty", 0, 0, 0, 0);
    checkOutput("empty_busy_after", int'(busy), 0);

    startFrame(); frag(make_tex(1, 0), 2, 5); endFrame(); drainAll("offset");
    checkLanes("offset", 0, 0, 0, 1);

    startFrame(); frag(make_tex(1, 100), 0, 9); frag(make_tex(1, 50), 15, 9);
    frag(make_tex(1, 200), 1, 8); endFrame(); drainAll("aligned");
    checkLanes("aligned", 100, 101, 102, 103);

    startFrame(); frag(make_tex(0, 10), 0, 5); frag(make_tex(0, 20), 0, 3);
    endFrame(); drainAll("near_first");
    checkLanes("near_first", 10, 10, 10, 10);
    startFrame(); frag(make_tex(0, 20), 0, 3); frag(make_tex(0, 10), 0, 5);
    endFrame(); drainAll("far_first");
    checkLanes("far_first", 10, 10, 10, 10);

    startFrame(); frag(make_tex(0, 7), 0, 2); frag(make_tex(0, 255), 0, 4);
    endFrame(); drainAll("key_skip");
    checkLanes("key_skip", 7, 7, 7, 7);
    startFrame(); frag(make_tex(0, 255), 0, 0); endFrame(); drainAll("key_z0");
    checkLanes("key_z0", 255, 255, 255, 255);

    startFrame(); frag(make_tex(0, 10), 0, 5); frag(make_tex(0, 21), 0, 5);
    endFrame(); drainAll("equal_z");
`ifdef SPRITE_LANE_BLEND_EN
    checkLanes("equal_z", 15, 15, 15, 15);
`else
    checkLanes("equal_z", 21, 21, 21, 21);
`endif

    startFrame(); frag(make_tex(0, 30), 0, 5);
    applyStimulus(1, 0, 1, make_tex(0, 40), 0, 6, 0);
    applyStimulus(0, 1, 1, make_tex(0, 60), 0, 9, 0);
    applyStimulus(0, 1, 1, make_tex(0, 50), 0, 1, 0);
    drainAll("restart");
    checkLanes("restart", 50, 50, 50, 50);

    startFrame(); frag(make_tex(1, 100), 0, 9); endFrame();
    for (int s = 0; s < 3; s++) begin
      idleCycle();
      checkOutput("stall0_color", int'(out_color), 100);
      checkOutput("stall0_last", int'(out_last), 0);
    end
    repeat (3) applyStimulus(0, 0, 0, '0, 0, 0, 1);
    for (int s = 0; s < 3; s++) begin
      idleCycle();
      checkOutput("stall3_color", int'(out_color), 103);
      checkOutput("stall3_last", int'(out_last), 1);
    end
    reset = 1'b1;
    #1;
    checkOutput("mid_drain_rst_valid", int'(out_valid), 0);
    checkOutput("mid_drain_rst_color", int'(out_color), BG);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) idleCycle();
    checkOutput("post_rst_valid", int'(out_valid), 0);

    startFrame(); frag(make_tex(0, 77), 0, 4);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    idleCycle();
    startFrame(); endFrame(); drainAll("after_accept_rst");
    checkLanes("after_accept_rst", 0, 0, 0, 0);

    repeat (2) idleCycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
